multicycle_ctrl_fsm: RTL and testbench

//  Multi-cycle sequencer for the RV32I core datapath: steps each instruction through

---
 rtl/riscv_ctrl_pkg.sv | 33 +++
 rtl/mem_wait_timer.sv | 32 +++
 rtl/multicycle_ctrl_fsm.sv | 149 ++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the RV32I multi-cycle control path: opcodes, FSM states, PC select values.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic PC_SEL_SEQ = 1'b0;
  localparam logic PC_SEL_TGT = 1'b1;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5,
    ST_FAULT  = 3'd6
  } state_t;

  function automatic logic is_legal_op(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-state counter shared by instruction fetch and data access; flags a timeout
// once LIMIT wait cycles have elapsed without ready.
module mem_wait_timer #(
  parameter int LIMIT = 255,
  parameter int W     = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_count_en,
  input  logic i_ready,
  output logic o_expired
);

  logic [W-1:0] r_cnt;
  logic         w_at_limit;

  assign w_at_limit = (r_cnt == W'(LIMIT));
  assign o_expired  = w_at_limit && !i_ready;

  // Saturates at LIMIT so a held timeout never wraps back to a small count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_count_en && !w_at_limit) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle sequencer for the RV32I datapath: FETCH/DECODE/EXEC/MEM/WB timing strobes,
// memory request handshakes with wait-state timeout, and halt/fault control.
module multicycle_ctrl_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  localparam int TO_W = $clog2(MEM_TIMEOUT + 1)
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [6:0] i_opcode,
  input  logic       i_branch_taken,
  input  logic       i_if_ready,
  input  logic       i_dm_ready,
  input  logic       i_halt,
  output logic       o_if_req,
  output logic       o_ir_we,
  output logic       o_pc_we,
  output logic       o_pc_sel,
  output logic       o_rf_we,
  output logic       o_dm_req,
  output logic       o_dm_we,
  output logic       o_retire,
  output logic       o_illegal_instr,
  output logic       o_bus_err,
  output logic       o_halted
);

  state_t r_state;
  state_t w_next;

  logic w_if_req, w_ir_we, w_pc_we, w_pc_sel, w_rf_we, w_dm_req, w_dm_we;
  logic w_retire, w_illegal, w_bus_err, w_halted;
  logic w_req, w_ready, w_expired;

  // Only the FETCH and MEM states hold a request open; every other state keeps the timer cleared.
  assign w_req   = (r_state == ST_FETCH) || (r_state == ST_MEM);
  assign w_ready = ((r_state == ST_FETCH) && i_if_ready) || ((r_state == ST_MEM) && i_dm_ready);

  mem_wait_timer #(
    .LIMIT (MEM_TIMEOUT),
    .W     (TO_W)
  ) u_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clear    (!w_req || w_ready),
    .i_count_en (w_req && !w_ready),
    .i_ready    (w_ready),
    .o_expired  (w_expired)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_if_req  = 1'b0;
    w_ir_we   = 1'b0;
    w_pc_we   = 1'b0;
    w_pc_sel  = PC_SEL_SEQ;
    w_rf_we   = 1'b0;
    w_dm_req  = 1'b0;
    w_dm_we   = 1'b0;
    w_retire  = 1'b0;
    w_illegal = 1'b0;
    w_bus_err = 1'b0;
    w_halted  = 1'b0;
    case (r_state)
      ST_FETCH: begin
        w_if_req = 1'b1;
        if (i_if_ready) begin
          w_ir_we = 1'b1;
          w_pc_we = 1'b1;
          w_next  = ST_DECODE;
        end else if (w_expired) begin
          w_bus_err = 1'b1;
          w_next    = ST_FAULT;
        end
      end
      ST_DECODE: begin
        if (is_legal_op(i_opcode)) begin
          w_next = ST_EXEC;
        end else begin
          w_illegal = 1'b1;
          w_next    = ST_FETCH;
        end
      end
      ST_EXEC: begin
        case (i_opcode)
          OP_BRANCH: begin
            w_pc_we  = i_branch_taken;
            w_pc_sel = PC_SEL_TGT;
            w_retire = 1'b1;
            w_next   = i_halt ? ST_HALT : ST_FETCH;
          end
          OP_JAL: begin
            w_pc_we  = 1'b1;
            w_pc_sel = PC_SEL_TGT;
            w_next   = ST_WB;
          end
          OP_LOAD, OP_STORE: w_next = ST_MEM;
          default:           w_next = ST_WB;
        endcase
      end
      ST_MEM: begin
        w_dm_req = 1'b1;
        w_dm_we  = (i_opcode == OP_STORE);
        if (i_dm_ready) begin
          if (i_opcode == OP_STORE) begin
            w_retire = 1'b1;
            w_next   = i_halt ? ST_HALT : ST_FETCH;
          end else begin
            w_next = ST_WB;
          end
        end else if (w_expired) begin
          w_bus_err = 1'b1;
          w_next    = ST_FAULT;
        end
      end
      ST_WB: begin
        w_rf_we  = 1'b1;
        w_retire = 1'b1;
        w_next   = i_halt ? ST_HALT : ST_FETCH;
      end
      ST_HALT: begin
        w_halted = 1'b1;
        if (!i_halt) w_next = ST_FETCH;
      end
      ST_FAULT: w_halted = 1'b1;
      default:  w_next = ST_FETCH;
    endcase
  end

  // Reset gates every output in the same cycle so an open request is dropped immediately.
  assign o_if_req        = w_if_req  & ~i_rst;
  assign o_ir_we         = w_ir_we   & ~i_rst;
  assign o_pc_we         = w_pc_we   & ~i_rst;
  assign o_pc_sel        = w_pc_sel  & ~i_rst;
  assign o_rf_we         = w_rf_we   & ~i_rst;
  assign o_dm_req        = w_dm_req  & ~i_rst;
  assign o_dm_we         = w_dm_we   & ~i_rst;
  assign o_retire        = w_retire  & ~i_rst;
  assign o_illegal_instr = w_illegal & ~i_rst;
  assign o_bus_err       = w_bus_err & ~i_rst;
  assign o_halted        = w_halted  & ~i_rst;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench: each driven cycle pushes its expected output vector, a monitor pops and compares.
module tb_multicycle_ctrl_fsm;
  import riscv_ctrl_pkg::*;

  localparam logic [10:0] IFREQ  = 11'h400;
  localparam logic [10:0] IRWE   = 11'h200;
  localparam logic [10:0] PCWE   = 11'h100;
  localparam logic [10:0] PCSEL  = 11'h080;
  localparam logic [10:0] RFWE   = 11'h040;
  localparam logic [10:0] DMREQ  = 11'h020;
  localparam logic [10:0] DMWE   = 11'h010;
  localparam logic [10:0] RETIRE = 11'h008;
  localparam logic [10:0] ILL    = 11'h004;
  localparam logic [10:0] BUSERR = 11'h002;
  localparam logic [10:0] HALTED = 11'h001;
  localparam logic [10:0] FETCHOK = IFREQ | IRWE | PCWE;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic branchTaken = 1'b0, ifReady = 1'b0, dmReady = 1'b0, haltIn = 1'b0;
  logic ifReq, irWe, pcWe, pcSel, rfWe, dmReq, dmWe, retire, illegalInstr, busErr, halted;

  int checks = 0;
  int failures = 0;
  string tagQ[$];
  logic [10:0] expQ[$];

  multicycle_ctrl_fsm #(.MEM_TIMEOUT(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_opcode(opcode), .i_branch_taken(branchTaken),
    .i_if_ready(ifReady), .i_dm_ready(dmReady), .i_halt(haltIn),
    .o_if_req(ifReq), .o_ir_we(irWe), .o_pc_we(pcWe), .o_pc_sel(pcSel), .o_rf_we(rfWe),
    .o_dm_req(dmReq), .o_dm_we(dmWe), .o_retire(retire), .o_illegal_instr(illegalInstr),
    .o_bus_err(busErr), .o_halted(halted)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input string tag, input logic [6:0] op, input logic ifr, input logic dmr,
                               input logic bt, input logic hlt, input logic rstv, input logic [10:0] exp);
    @(negedge clk);
    opcode = op; ifReady = ifr; dmReady = dmr; branchTaken = bt; haltIn = hlt; rst = rstv;
    tagQ.push_back(tag);
    expQ.push_back(exp);
  endtask

  task automatic fetchOk(input string tag, input logic [6:0] op);
    applyStimulus(tag, op, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, FETCHOK);
  endtask

  // Monitor samples between edges, after the stimulus for this cycle has settled.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (expQ.size() > 0) begin
        checkOutput(tagQ.pop_front(),
                    {21'd0, ifReq, irWe, pcWe, pcSel, rfWe, dmReq, dmWe, retire, illegalInstr, busErr, halted},
                    {21'd0, expQ.pop_front()});
      end
    end
  end

  initial begin
    $display("[TB] start");
    applyStimulus("reset", OP_R, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 11'h000);

    fetchOk("r_fetch", OP_R);
    applyStimulus("r_decode", OP_R, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 11'h000);
    applyStimulus("r_exec", OP_R, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'h000);
    applyStimulus("r_wb", OP_R, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, RFWE | RETIRE);

    fetchOk("ld_fetch", OP_LOAD);
    applyStimulus("ld_decode", OP_LOAD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000);
    applyStimulus("ld_exec", OP_LOAD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000);
    for (int i = 0; i < 3; i++)
      applyStimulus("ld_mem_wait", OP_LOAD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, DMREQ);
    applyStimulus("ld_mem_ready", OP_LOAD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, DMREQ);
    applyStimulus("ld_wb", OP_LOAD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, RFWE | RETIRE);

    fetchOk("bt_fetch", OP_BRANCH);
    applyStimulus("bt_decode", OP_BRANCH, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 11'h000);
    applyStimulus("bt_exec", OP_BRANCH, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, PCWE | PCSEL | RETIRE);
    fetchOk("bn_fetch", OP_BRANCH);
    applyStimulus("bn_decode", OP_BRANCH, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000);
    applyStimulus("bn_exec", OP_BRANCH, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, PCSEL | RETIRE);

    fetchOk("ill_fetch", 7'b0000000);
    applyStimulus("ill_decode", 7'b0000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ILL);
    applyStimulus("ill_refetch", OP_STORE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, IFREQ);

    fetchOk("st_fetch", OP_STORE);
    applyStimulus("st_decode", OP_STORE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000);
    applyStimulus("st_exec", OP_STORE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000);
    applyStimulus("st_mem", OP_STORE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, DMREQ | DMWE | RETIRE);

    fetchOk("jal_fetch", OP_JAL);
    applyStimulus("jal_decode", OP_JAL, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000);
    applyStimulus("jal_exec", OP_JAL, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, PCWE | PCSEL);
    applyStimulus("jal_wb", OP_JAL, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, RFWE | RETIRE);

    // Fetch ready arriving on the timeout cycle must still win over the fault.
    for (int i = 0; i < 4; i++)
      applyStimulus("lui_fetch_wait", OP_LUI, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, IFREQ);
    fetchOk("lui_fetch_edge", OP_LUI);
    applyStimulus("lui_decode", OP_LUI, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000);
    applyStimulus("lui_exec", OP_LUI, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000);
    applyStimulus("lui_wb_halt", OP_LUI, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, RFWE | RETIRE);
    applyStimulus("halt_hold", OP_LUI, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, HALTED);
    applyStimulus("halt_release", OP_LUI, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, HALTED);
    fetchOk("i_fetch", OP_I);
    applyStimulus("i_decode", OP_I, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000);
    applyStimulus("i_exec", OP_I, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000);
    applyStimulus("i_wb", OP_I, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, RFWE | RETIRE);

    fetchOk("rst_fetch", OP_LOAD);
    applyStimulus("rst_decode", OP_LOAD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000);
    applyStimulus("rst_exec", OP_LOAD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000);
    applyStimulus("rst_mem_wait", OP_LOAD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, DMREQ);
    applyStimulus("rst_mem_drop", OP_LOAD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 11'h000);
    applyStimulus("rst_after", OP_AUIPC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, IFREQ);

    fetchOk("to_fetch", OP_LOAD);
    applyStimulus("to_decode", OP_LOAD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000);
    applyStimulus("to_exec", OP_LOAD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000);
    for (int i = 0; i < 4; i++)
      applyStimulus("to_mem_wait", OP_LOAD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, DMREQ);
    applyStimulus("to_mem_expire", OP_LOAD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, DMREQ | BUSERR);
    for (int i = 0; i < 3; i++)
      applyStimulus("fault_sticky", OP_LOAD, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, HALTED);
    applyStimulus("fault_reset", OP_R, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 11'h000);
    fetchOk("post_fault_fetch", OP_R);

    @(negedge clk);
    @(negedge clk);
    checkOutput("scoreboard_drained", expQ.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
